// File: rtl/halfword_packer_pkg.sv
// Shared types and widths for the halfword packer: pack FSM states,
// datapath widths and the FIFO entry layout.
package halfword_packer_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    // Pack FSM: LOW = holding register empty, HIGH = low half held.
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_e;

    // One FIFO entry: half-select flag plus the packed word.
    // sel = 1 marks a partial word where only [15:0] carries data.
    typedef struct packed {
        logic              sel;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Build an entry from its fields.
    function automatic fifo_entry_t make_entry(input logic sel, input logic [WORD_W-1:0] data);
        fifo_entry_t e;
        e.sel  = sel;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/halfword_packer_if.sv
// Stream interface of the halfword packer: 16-bit halfwords in,
// 32-bit packed words out, plus the popped-word counter.
interface halfword_packer_if;
    import halfword_packer_pkg::*;

    // Input halfword stream
    logic              valid_i;
    logic              ready_o;
    logic [HALF_W-1:0] data_i;
    logic              last_i;

    // Output word stream
    logic              valid_o;
    logic              ready_i;
    logic [WORD_W-1:0] data_o;
    logic              sel_o;
    logic [CNT_W-1:0]  word_cnt_o;

    // Packer side
    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, sel_o, word_cnt_o
    );

    // Upstream/downstream side
    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, sel_o, word_cnt_o
    );

endinterface

// File: rtl/halfword_packer_sync_fifo.sv
// Synchronous FIFO with registered head output and no bypass.
// DEPTH must be a power of two, at least 2; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this cycle, so a push into a full FIFO is
    // allowed when it coincides with a pop; a pop from empty is ignored.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; both pointers wrap modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            // NOTE: the storage is reset too, because the head entry drives
            // data_o directly and must read as zero while in reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, whatever the statement order.
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/halfword_packer.sv
// Packs pairs of 16-bit halfwords into 32-bit words; a packet ending on
// an odd halfword emits a partial word flagged with sel_o = 1. Packed
// words queue in a small FIFO and a 16-bit counter tracks words popped.
module halfword_packer
    import halfword_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    halfword_packer_if.slave   bus
);

    pack_state_e       state_q;
    pack_state_e       state_d;
    logic [HALF_W-1:0] held_q;
    logic              held_load;
    logic [CNT_W-1:0]  word_cnt_q;

    logic              in_xfer;
    logic              out_xfer;
    logic              push;
    fifo_entry_t       push_entry;
    fifo_entry_t       head_entry;
    logic              fifo_full;
    logic              fifo_empty;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (out_xfer),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output side: the head entry is shown straight from FIFO storage.
    assign bus.valid_o    = !fifo_empty;
    assign bus.data_o     = head_entry.data;
    assign bus.sel_o      = head_entry.sel;
    assign bus.word_cnt_o = word_cnt_q;

    assign out_xfer = bus.valid_o && bus.ready_i;
    assign in_xfer  = bus.valid_i && bus.ready_o;

    // Pack FSM next state, ready and push request; ready_o never looks
    // at valid_i, only at state, FIFO fullness and the output handshake.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned, which would infer a latch.
        state_d     = state_q;
        bus.ready_o = 1'b1;
        push        = 1'b0;
        push_entry  = '0;
        held_load   = 1'b0;

        unique case (state_q)
            LOW: begin
                if (in_xfer) begin
                    if (bus.last_i) begin
                        push       = 1'b1;
                        push_entry = make_entry(1'b1, {{HALF_W{1'b0}}, bus.data_i});
                    end else begin
                        held_load = 1'b1;
                        state_d   = HIGH;
                    end
                end
            end
            HIGH: begin
                bus.ready_o = !fifo_full || out_xfer;
                if (in_xfer) begin
                    push       = 1'b1;
                    push_entry = make_entry(1'b0, {bus.data_i, held_q});
                    state_d    = LOW;
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase
    end

    // Pack FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register for the low half; kept indefinitely while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_q <= '0;
        end else if (held_load) begin
            held_q <= bus.data_i;
        end
    end

    // Popped-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q <= '0;
        end else if (out_xfer) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_halfword_packer.sv
// Self-checking bench for halfword_packer: a scoreboard queue is filled
// from a reference model when halfwords are accepted and drained by a
// monitor whenever a word leaves the packer.
module tb_halfword_packer;
    import halfword_packer_pkg::*;

    localparam int DEPTH = 2;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    halfword_packer_if bus ();

    halfword_packer #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    // Scoreboard and reference model state
    fifo_entry_t exp_q[$];
    logic [15:0] m_held;
    bit          m_high;
    bit          mon_en;
    int          pop_count;

    // Reference model: what an accepted halfword should produce.
    task automatic model_accept(input logic [15:0] d, input logic l);
        fifo_entry_t e;
        if (!m_high) begin
            if (l) begin
                e.sel  = 1'b1;
                e.data = {16'h0000, d};
                exp_q.push_back(e);
            end else begin
                m_held = d;
                m_high = 1'b1;
            end
        end else begin
            e.sel  = 1'b0;
            e.data = {d, m_held};
            exp_q.push_back(e);
            m_high = 1'b0;
        end
    endtask

    // Monitor: a word is taken at the next rising edge when valid and
    // ready are both high at the falling edge.
    always @(negedge clk_i) begin : monitor
        fifo_entry_t e;
        if (rst_ni && bus.valid_o && bus.ready_i) begin
            pop_count++;
            if (mon_en) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data_o", 64'(bus.data_o), 64'(e.data));
                    check("sel_o", 64'(bus.sel_o), 64'(e.sel));
                end
            end
        end
    end

    // Offer one halfword until accepted (bounded); returns cycles spent.
    task automatic send(input logic [15:0] d, input logic l, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.last_i  = l;
        while (!acc && waited < 50) begin
            @(negedge clk_i);
            acc = bus.ready_o;
            @(posedge clk_i);
            #1;
            waited++;
        end
        bus.valid_i = 1'b0;
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        else model_accept(d, l);
    endtask

    // Wait (bounded) until every expected word has been observed.
    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 40) begin
            @(posedge clk_i);
            #1;
            i++;
        end
        @(posedge clk_i);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_o"}, 64'(bus.valid_o), 64'd0);
        check({tag, "_data_o"}, 64'(bus.data_o), 64'd0);
        check({tag, "_sel_o"}, 64'(bus.sel_o), 64'd0);
        check({tag, "_word_cnt_o"}, 64'(bus.word_cnt_o), 64'd0);
        check({tag, "_ready_o"}, 64'(bus.ready_o), 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        rst_ni      = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.last_i  = 1'b0;
        bus.ready_i = 1'b1;
        mon_en      = 1'b1;
        m_held      = '0;
        m_high      = 1'b0;
        pop_count   = 0;

        #23;
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Two halfwords -> one full word, one cycle after the second.
        send(16'h1111, 1'b0, w);
        check("t1_no_word_after_first", 64'(bus.valid_o), 64'd0);
        send(16'h2222, 1'b0, w);
        check("t1_valid_latency", 64'(bus.valid_o), 64'd1);
        @(posedge clk_i);
        #1;
        check("t1_word_cnt", 64'(bus.word_cnt_o), 64'd1);
        check("t1_fifo_empty", 64'(bus.valid_o), 64'd0);

        // Single halfword ending a packet -> partial word.
        send(16'hABCD, 1'b1, w);
        drain();
        check("t2_word_cnt", 64'(bus.word_cnt_o), 64'd2);

        // Backpressure: fill the FIFO, stall in HIGH, then release.
        bus.ready_i = 1'b0;
        send(16'h0A01, 1'b0, w);
        send(16'h0A02, 1'b0, w);
        send(16'h0B01, 1'b0, w);
        send(16'h0B02, 1'b0, w);
        send(16'h0C01, 1'b0, w);
        bus.valid_i = 1'b1;
        bus.data_i  = 16'h0C02;
        bus.last_i  = 1'b0;
        @(negedge clk_i);
        check("t3_ready_full_high", 64'(bus.ready_o), 64'd0);
        check("t3_valid_held", 64'(bus.valid_o), 64'd1);
        check("t3_head_stalled", 64'(bus.data_o), 64'h0A02_0A01);
        @(posedge clk_i);
        #1;
        check("t3_head_stable", 64'(bus.data_o), 64'h0A02_0A01);
        bus.ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_ready_on_pop", 64'(bus.ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        model_accept(16'h0C02, 1'b0);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        check("t3_head_advanced", 64'(bus.data_o), 64'h0B02_0B01);

        // Full FIFO, push and pop together in LOW: level stays full.
        bus.valid_i = 1'b1;
        bus.data_i  = 16'h0D0D;
        bus.last_i  = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk_i);
        check("t4_ready_low", 64'(bus.ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        model_accept(16'h0D0D, 1'b1);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        check("t4_head_advanced", 64'(bus.data_o), 64'h0C02_0C01);
        send(16'h0E01, 1'b0, w);
        bus.valid_i = 1'b1;
        bus.data_i  = 16'h0E02;
        bus.last_i  = 1'b0;
        @(negedge clk_i);
        check("t4_still_full", 64'(bus.ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drain();
        send(16'h0E02, 1'b0, w);
        drain();
        check("t4_word_cnt", 64'(bus.word_cnt_o), 64'd7);

        // Reset mid-cycle in HIGH with one word queued.
        bus.ready_i = 1'b0;
        send(16'h5111, 1'b0, w);
        send(16'h5222, 1'b0, w);
        send(16'h5333, 1'b0, w);
        check("t5_word_queued", 64'(bus.valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        exp_q.delete();
        m_high      = 1'b0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send(16'h0001, 1'b0, w);
        check("t5_first_edge_accept", 64'(w), 64'd1);
        send(16'h0002, 1'b0, w);
        drain();
        check("t5_idle_after", 64'(bus.valid_o), 64'd0);
        check("t5_word_cnt", 64'(bus.word_cnt_o), 64'd1);

        // Counter wrap: 65537 output transfers from reset -> 1.
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        mon_en      = 1'b0;
        pop_count   = 0;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = 16'h7777;
        bus.last_i  = 1'b1;
        repeat (65537) @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("t6_pop_count", 64'(pop_count), 64'd65537);
        check("t6_word_cnt_wrap", 64'(bus.word_cnt_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/halfword_packer.md
HALFWORD_PACKER -- requirements
Module: halfword_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of output FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit, meaning the reset, asynchronous and active-low.
REQ-004 The block SHALL have port valid_i, input, 1 bit, meaning an input halfword is offered.
REQ-005 The block SHALL have port ready_o, output, 1 bit, meaning the block accepts the offered halfword this cycle.
REQ-006 The block SHALL have port data_i, input, 16 bits, meaning the input halfword.
REQ-007 The block SHALL have port last_i, input, 1 bit, meaning the offered halfword ends a packet.
REQ-008 The block SHALL have port valid_o, output, 1 bit, meaning the FIFO head word is presented.
REQ-009 The block SHALL have port ready_i, input, 1 bit, meaning downstream takes the presented word.
REQ-010 The block SHALL have port data_o, output, 32 bits, meaning the packed word, with the first halfword in [15:0] and the second in [31:16].
REQ-011 The block SHALL have port sel_o, output, 1 bit, meaning 1 = only [15:0] is valid (partial word) and 0 = both halves are valid; it feeds the slicer half-select.
REQ-012 The block SHALL have port word_cnt_o, output, 16 bits, meaning the count of words popped since reset.

Function
REQ-013 An input transfer SHALL occur when valid_i and ready_o are both 1, and an output transfer when valid_o and ready_i are both 1.
REQ-014 The pack FSM SHALL have states LOW (empty holding register) and HIGH (low half held).
REQ-015 In LOW, ready_o SHALL be 1.
- Transfer with last_i=0: store data_i in the holding register and go to HIGH.
- Transfer with last_i=1: push {16'h0, data_i} with sel=1 and stay in LOW.
REQ-016 In HIGH, ready_o SHALL be 1 when the FIFO is not full, or when it is full and an output transfer occurs in the same cycle.
- Transfer: push {data_i, held} with sel=0 and go to LOW, regardless of last_i.
REQ-017 ready_o SHALL NOT depend combinationally on valid_i.
REQ-018 The FIFO SHALL have DEPTH entries of 33 bits (sel and data).
- Push and pop in the same cycle SHALL both take effect at any fill level, including full and empty.
- Pointers SHALL wrap modulo DEPTH.
REQ-019 valid_o SHALL be 1 exactly when the FIFO is non-empty, and data_o/sel_o SHALL show the head entry combinationally from registered state.
REQ-020 There SHALL be no bypass: latency from the completing input transfer to valid_o=1 is exactly 1 cycle.
REQ-021 data_o and sel_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-022 word_cnt_o SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-023 A halfword held in HIGH SHALL be kept indefinitely while valid_i=0 (no timeout flush).

Reset
REQ-024 Asserting rst_ni=0 SHALL immediately, without waiting for a clock edge:
- force the FSM to LOW;
- empty the FIFO;
- clear the holding register and word_cnt_o to 0.
REQ-025 During reset, outputs SHALL be valid_o=0, data_o=0, sel_o=0 and word_cnt_o=0; ready_o SHALL read 1 but no transfer is taken.
REQ-026 Reset mid-packet SHALL discard the held halfword and all FIFO contents, with no partial word emitted.
REQ-027 The first transfer after reset SHALL be accepted on the first rising edge after rst_ni returns to 1.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (LOW, HIGH), the halfword width 16, the word width 32 and the FIFO entry struct {sel, data}.
REQ-029 The FIFO SHALL be a separate sub-module named sync_fifo, parameterised by width and DEPTH, exposing full and empty flags.

Verification
REQ-030 The bench SHALL cover the following directed scenarios.
- Reset, then halfwords 16'h1111 then 16'h2222 (last_i=0), ready_i=1 -> one word 32'h2222_1111, sel_o=0, valid_o one cycle after the second transfer, word_cnt_o=1.
- Single halfword 16'hABCD with last_i=1 in LOW -> word 32'h0000_ABCD, sel_o=1.
- ready_i=0 while streaming pairs, DEPTH=2 -> two words stored, then ready_o=0 in HIGH; raise ready_i -> same-cycle pop and push, no word lost or duplicated, order preserved.
- FIFO full with push and pop in the same cycle -> fill level unchanged and the head advances.
- rst_ni pulsed low mid-cycle while in HIGH with 1 word queued -> valid_o drops immediately; after release, 16'h0001 and 16'h0002 -> 32'h0002_0001 only.
- Preload word_cnt_o near wrap with 65537 output transfers -> word_cnt_o=1.
